// File: rtl/sram_array_ctrl.sv
// DEPTH x WIDTH behavioural SRAM macro with a write / precharge-wordline-sense sequencer.
// Bitlines are modelled as real voltages and classified against the logic-level windows.
module sram_array_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned PRE_CYC   = 1,
    parameter int unsigned SENSE_CYC = 1,
    parameter real         TRUE_MIN  = 1.3,
    parameter real         TRUE_MAX  = 2.2,
    parameter real         FALSE_MIN = -0.5,
    parameter real         FALSE_MAX = 0.7
) (
    input  logic              clk,
    input  logic              rst,
    input  real               vdd_in,
    input  real               vss_in,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [WIDTH-1:0]  cmd_wdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err,
    output logic [DEPTH-1:0]  row_wr,
    output logic [DEPTH-1:0]  row_rd
);

    localparam int unsigned MaxCyc = (PRE_CYC > SENSE_CYC) ? PRE_CYC : SENSE_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    typedef enum logic [2:0] {StIdle, StWrite, StPre, StWl, StSense, StDone} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WIDTH-1:0]  wdata_q;
    logic [CntW-1:0]   cnt_q;
    logic              unwritten_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH-1:0]  written_q;
    real               bl_q [WIDTH];

    logic [WIDTH-1:0]  sense_data;
    logic              sense_indet;

    function automatic logic in_win(real v, real lo, real hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Per-bit sense amplifier on the latched bitline voltages.
    always_comb begin
        sense_data  = '0;
        sense_indet = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (in_win(bl_q[i], TRUE_MIN, TRUE_MAX)) begin
                sense_data[i] = 1'b1;
            end else if (!in_win(bl_q[i], FALSE_MIN, FALSE_MAX)) begin
                sense_indet = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            row_wr      <= '0;
            row_rd      <= '0;
            written_q   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            unwritten_q <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                bl_q[i] <= 0.0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        cmd_ready <= 1'b0;
                        cnt_q     <= '0;
                        if (32'(cmd_addr) >= DEPTH) begin
                            state_q   <= StDone;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (cmd_we) begin
                            state_q <= StWrite;
                            row_wr  <= DEPTH'(1) << cmd_addr;
                        end else begin
                            state_q <= StPre;
                        end
                    end
                end
                StWrite: begin
                    row_wr    <= '0;
                    state_q   <= StDone;
                    rsp_valid <= 1'b1;
                    // A sagging supply cannot flip cells reliably, so the write is refused.
                    if (in_win(vdd_in, TRUE_MIN, TRUE_MAX)) begin
                        mem_q[addr_q]     <= wdata_q;
                        written_q[addr_q] <= 1'b1;
                        rsp_err           <= 1'b0;
                    end else begin
                        rsp_err <= 1'b1;
                    end
                end
                StPre: begin
                    if (cnt_q == CntW'(PRE_CYC - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StWl;
                        row_rd  <= DEPTH'(1) << addr_q;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWl: begin
                    row_rd      <= '0;
                    state_q     <= StSense;
                    unwritten_q <= !written_q[addr_q];
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        bl_q[i] <= mem_q[addr_q][i] ? vdd_in : vss_in;
                    end
                end
                StSense: begin
                    if (cnt_q == CntW'(SENSE_CYC - 1)) begin
                        cnt_q     <= '0;
                        state_q   <= StDone;
                        rsp_valid <= 1'b1;
                        if (unwritten_q) begin
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                        end else begin
                            rsp_rdata <= sense_data;
                            rsp_err   <= sense_indet;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Randomised and directed bench for sram_array_ctrl (DEPTH=12) against a transaction-level
// model of the word array, written flags and voltage-window classification.
module tb_sram_array_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 12;
    localparam int unsigned AW    = 4;
    localparam int unsigned PRE   = 1;
    localparam int unsigned SENSE = 1;
    localparam real T_MIN = 1.3;
    localparam real T_MAX = 2.2;
    localparam real F_MIN = -0.5;
    localparam real F_MAX = 0.7;
    // Off-window supplies applied outside WRITE/WL; they must never be observed.
    localparam real NZ_VDD = 0.2;
    localparam real NZ_VSS = 1.6;

    logic             clk = 1'b0;
    logic             rst;
    real              vdd, vss;
    logic             cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0]    cmd_addr;
    logic [WIDTH-1:0] cmd_wdata;
    logic             rsp_valid, rsp_err;
    logic [WIDTH-1:0] rsp_rdata;
    logic [DEPTH-1:0] row_wr, row_rd;

    int checks = 0;
    int fails  = 0;

    logic [WIDTH-1:0] ref_mem [16];
    bit               ref_written [16];

    sram_array_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .PRE_CYC(PRE), .SENSE_CYC(SENSE),
        .TRUE_MIN(T_MIN), .TRUE_MAX(T_MAX), .FALSE_MIN(F_MIN), .FALSE_MAX(F_MAX)
    ) dut (
        .clk(clk), .rst(rst), .vdd_in(vdd), .vss_in(vss),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .row_wr(row_wr), .row_rd(row_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Spec-level expectation for one command; updates the reference array.
    task automatic model(input bit we, input int addr, input logic [7:0] wdata,
                         input real v, input real s, output int ecyc,
                         output logic [7:0] edata, output logic eerr,
                         output int ewr, output int erd);
        real bl;
        edata = '0; eerr = 1'b0; ewr = -1; erd = -1;
        if (addr >= int'(DEPTH)) begin
            ecyc = 1; eerr = 1'b1;
        end else if (we) begin
            ecyc = 2; ewr = 1;
            if (v >= T_MIN && v <= T_MAX) begin
                ref_mem[addr] = wdata; ref_written[addr] = 1'b1;
            end else begin
                eerr = 1'b1;
            end
        end else begin
            ecyc = int'(PRE + SENSE) + 2; erd = int'(PRE) + 1;
            if (!ref_written[addr]) begin
                eerr = 1'b1;
            end else begin
                for (int b = 0; b < 8; b++) begin
                    bl = ref_mem[addr][b] ? v : s;
                    if (bl >= T_MIN && bl <= T_MAX) edata[b] = 1'b1;
                    else if (!(bl >= F_MIN && bl <= F_MAX)) eerr = 1'b1;
                end
            end
        end
    endtask

    // Drives one command from just after a falling edge; returns just after the falling edge
    // of the first idle cycle after the response, so calls chain at full throughput.
    task automatic run_cmd(input bit we, input logic [AW-1:0] addr, input logic [7:0] wdata,
                           input real act_vdd, input real act_vss, output int rcyc,
                           output logic [7:0] rdata, output logic rerr,
                           output int wr_cyc, output int rd_cyc, output int bad);
        int act_c;
        bit done;
        logic [DEPTH-1:0] onehot;
        onehot = '0;
        if (int'(addr) < int'(DEPTH)) onehot[addr] = 1'b1;
        act_c = we ? 1 : int'(PRE) + 1;
        rcyc = 0; rdata = '0; rerr = 1'b0; wr_cyc = -1; rd_cyc = -1; bad = 0;
        if (cmd_ready !== 1'b1) bad++;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata;
        vdd = NZ_VDD; vss = NZ_VSS;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_addr = AW'($urandom);
        cmd_wdata = WIDTH'($urandom);
        done = 1'b0;
        for (int c = 1; c <= 20 && !done; c++) begin
            vdd = (c == act_c) ? act_vdd : NZ_VDD;
            vss = (c == act_c) ? act_vss : NZ_VSS;
            @(negedge clk);
            if (rcyc != 0) begin
                if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) bad++;
                done = 1'b1;
            end else begin
                if (cmd_ready !== 1'b0) bad++;
                if (rsp_valid === 1'b1) begin
                    rcyc = c; rdata = rsp_rdata; rerr = rsp_err;
                end else if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin
                    bad++;
                end
            end
            if (row_wr !== '0 && row_rd !== '0) bad++;
            if (row_wr !== '0) wr_cyc = (wr_cyc == -1 && row_wr === onehot) ? c : -2;
            if (row_rd !== '0) rd_cyc = (rd_cyc == -1 && row_rd === onehot) ? c : -2;
            if (!done) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        vdd = 1.5; vss = 0.0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin fails++;
            $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin fails++;
            $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_rdata !== '0 || rsp_err !== 1'b0) begin fails++;
            $display("FAIL reset_rsp: got %h/%b expected 00/0", rsp_rdata, rsp_err); end
        checks++; if (row_wr !== '0 || row_rd !== '0) begin fails++;
            $display("FAIL reset_rows: got %h/%h expected 0/0", row_wr, row_rd); end
    endtask

    task automatic test_unwritten();
        int rc, wc, rdc, bad, ec, ew, er; logic [7:0] rd, ed; logic re, ee;
        run_cmd(1'b0, 4'd5, 8'h00, 1.5, 0.0, rc, rd, re, wc, rdc, bad);
        model(1'b0, 5, 8'h00, 1.5, 0.0, ec, ed, ee, ew, er);
        checks++; if (rd !== ed || re !== ee) begin fails++;
            $display("FAIL unwritten_rsp: got %h/%b expected %h/%b", rd, re, ed, ee); end
        checks++; if (rdc !== er || wc !== ew) begin fails++;
            $display("FAIL unwritten_row_rd: got cyc %0d expected %0d", rdc, er); end
        checks++; if (rc !== ec || bad !== 0) begin fails++;
            $display("FAIL unwritten_timing: got cyc %0d bad %0d expected %0d 0", rc, bad, ec); end
    endtask

    task automatic test_write_read();
        int rc, wc, rdc, bad, ec, ew, er; logic [7:0] rd, ed; logic re, ee;
        run_cmd(1'b1, 4'd3, 8'hA5, 1.5, 0.0, rc, rd, re, wc, rdc, bad);
        model(1'b1, 3, 8'hA5, 1.5, 0.0, ec, ed, ee, ew, er);
        checks++; if (rc !== ec || re !== ee || rd !== ed) begin fails++;
            $display("FAIL write_rsp: got cyc %0d err %b expected %0d %b", rc, re, ec, ee); end
        checks++; if (wc !== ew || rdc !== er || bad !== 0) begin fails++;
            $display("FAIL write_rows: got wr %0d rd %0d bad %0d expected %0d %0d 0",
                     wc, rdc, bad, ew, er); end
        run_cmd(1'b0, 4'd3, 8'h00, 1.5, 0.0, rc, rd, re, wc, rdc, bad);
        model(1'b0, 3, 8'h00, 1.5, 0.0, ec, ed, ee, ew, er);
        checks++; if (rc !== ec) begin fails++;
            $display("FAIL read_latency: got %0d expected %0d", rc, ec); end
        checks++; if (rd !== ed || re !== ee) begin fails++;
            $display("FAIL read_data: got %h/%b expected %h/%b", rd, re, ed, ee); end
    endtask

    task automatic test_low_vdd();
        int rc, wc, rdc, bad, ec, ew, er; logic [7:0] rd, ed; logic re, ee;
        run_cmd(1'b1, 4'd3, 8'hFF, 1.0, 0.0, rc, rd, re, wc, rdc, bad);
        model(1'b1, 3, 8'hFF, 1.0, 0.0, ec, ed, ee, ew, er);
        checks++; if (re !== ee || rc !== ec) begin fails++;
            $display("FAIL lowvdd_err: got %b expected %b", re, ee); end
        run_cmd(1'b0, 4'd3, 8'h00, 1.5, 0.0, rc, rd, re, wc, rdc, bad);
        model(1'b0, 3, 8'h00, 1.5, 0.0, ec, ed, ee, ew, er);
        checks++; if (rd !== ed || re !== ee) begin fails++;
            $display("FAIL lowvdd_keep: got %h/%b expected %h/%b", rd, re, ed, ee); end
    endtask

    task automatic test_indet();
        int rc, wc, rdc, bad, ec, ew, er; logic [7:0] rd, ed; logic re, ee;
        run_cmd(1'b1, 4'd7, 8'h0F, 1.5, 0.0, rc, rd, re, wc, rdc, bad);
        model(1'b1, 7, 8'h0F, 1.5, 0.0, ec, ed, ee, ew, er);
        run_cmd(1'b0, 4'd7, 8'h00, 1.5, 0.9, rc, rd, re, wc, rdc, bad);
        model(1'b0, 7, 8'h00, 1.5, 0.9, ec, ed, ee, ew, er);
        checks++; if (rd !== ed || re !== ee) begin fails++;
            $display("FAIL indet_read: got %h/%b expected %h/%b", rd, re, ed, ee); end
    endtask

    task automatic test_bad_addr();
        int rc, wc, rdc, bad, ec, ew, er; logic [7:0] rd, ed; logic re, ee;
        logic [AW-1:0] addrs [3];
        addrs = '{4'd13, 4'd12, 4'd15};
        for (int k = 0; k < 3; k++) begin
            run_cmd(k[0] == 1'b0, addrs[k], 8'h3C, 1.5, 0.0, rc, rd, re, wc, rdc, bad);
            model(k[0] == 1'b0, int'(addrs[k]), 8'h3C, 1.5, 0.0, ec, ed, ee, ew, er);
            checks++; if (rc !== ec || re !== ee || rd !== ed) begin fails++;
                $display("FAIL badaddr_rsp: addr %0d got cyc %0d %h/%b expected %0d %h/%b",
                         addrs[k], rc, rd, re, ec, ed, ee); end
            checks++; if (wc !== ew || rdc !== er || bad !== 0) begin fails++;
                $display("FAIL badaddr_rows: got wr %0d rd %0d bad %0d expected -1 -1 0",
                         wc, rdc, bad); end
        end
        run_cmd(1'b0, 4'd3, 8'h00, 1.5, 0.0, rc, rd, re, wc, rdc, bad);
        model(1'b0, 3, 8'h00, 1.5, 0.0, ec, ed, ee, ew, er);
        checks++; if (rd !== ed || re !== ee) begin fails++;
            $display("FAIL badaddr_array: got %h/%b expected %h/%b", rd, re, ed, ee); end
    endtask

    task automatic test_back_to_back();
        int rc, wc, rdc, bad, ec, ew, er; logic [7:0] rd, ed; logic re, ee;
        for (int k = 0; k < 8; k++) begin
            logic [AW-1:0] a;
            logic [7:0] d;
            a = AW'(k / 2); d = 8'($urandom);
            run_cmd(k[0] == 1'b0, a, d, 1.8, -0.2, rc, rd, re, wc, rdc, bad);
            model(k[0] == 1'b0, int'(a), d, 1.8, -0.2, ec, ed, ee, ew, er);
            checks++; if (rc !== ec || rd !== ed || re !== ee) begin fails++;
                $display("FAIL b2b_rsp: k %0d got cyc %0d %h/%b expected %0d %h/%b",
                         k, rc, rd, re, ec, ed, ee); end
            checks++; if (wc !== ew || rdc !== er || bad !== 0) begin fails++;
                $display("FAIL b2b_proto: k %0d got wr %0d rd %0d bad %0d expected %0d %0d 0",
                         k, wc, rdc, bad, ew, er); end
        end
    endtask

    task automatic test_reset_mid();
        int rc, wc, rdc, bad, ec, ew, er; logic [7:0] rd, ed; logic re, ee;
        bit seen;
        for (int k = 0; k < 2; k++) begin
            cmd_valid = 1'b1; cmd_we = (k == 0); cmd_addr = 4'd3; cmd_wdata = 8'h5A;
            vdd = 1.5; vss = 0.0;
            @(posedge clk); #1;
            cmd_valid = 1'b0; rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            checks++; if (cmd_ready !== 1'b1) begin fails++;
                $display("FAIL midrst_ready: k %0d got %b expected 1", k, cmd_ready); end
            seen = 1'b0;
            for (int c = 0; c < 6; c++) begin
                if (rsp_valid !== 1'b0 || row_wr !== '0 || row_rd !== '0) seen = 1'b1;
                if (c < 5) @(negedge clk);
            end
            checks++; if (seen) begin fails++;
                $display("FAIL midrst_quiet: k %0d got activity expected none", k); end
            for (int i = 0; i < 16; i++) ref_written[i] = 1'b0;
        end
        run_cmd(1'b0, 4'd3, 8'h00, 1.5, 0.0, rc, rd, re, wc, rdc, bad);
        model(1'b0, 3, 8'h00, 1.5, 0.0, ec, ed, ee, ew, er);
        checks++; if (rd !== ed || re !== ee) begin fails++;
            $display("FAIL midrst_flags: got %h/%b expected %h/%b", rd, re, ed, ee); end
    endtask

    task automatic test_random();
        int rc, wc, rdc, bad, ec, ew, er; logic [7:0] rd, ed; logic re, ee;
        real vdd_tab [8];
        real vss_tab [8];
        vdd_tab = '{1.5, 1.3, 2.2, 1.8, 1.5, 1.0, 2.5, 1.29};
        vss_tab = '{0.0, -0.5, 0.7, 0.2, 0.0, 0.9, -0.8, 0.71};
        for (int k = 0; k < 120; k++) begin
            bit we; logic [AW-1:0] a; logic [7:0] d; real v, s;
            we = (k < 20) ? 1'b1 : 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 15)); d = 8'($urandom);
            v = vdd_tab[$urandom_range(0, 7)]; s = vss_tab[$urandom_range(0, 7)];
            run_cmd(we, a, d, v, s, rc, rd, re, wc, rdc, bad);
            model(we, int'(a), d, v, s, ec, ed, ee, ew, er);
            checks++; if (rc !== ec || rd !== ed || re !== ee) begin fails++;
                $display("FAIL rand_rsp: k %0d we %b a %0d got cyc %0d %h/%b expected %0d %h/%b",
                         k, we, a, rc, rd, re, ec, ed, ee); end
            checks++; if (wc !== ew || rdc !== er || bad !== 0) begin fails++;
                $display("FAIL rand_proto: k %0d got wr %0d rd %0d bad %0d expected %0d %0d 0",
                         k, wc, rdc, bad, ew, er); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = '0; ref_written[i] = 1'b0;
        end
        test_reset();
        test_unwritten();
        test_write_read();
        test_low_vdd();
        test_indet();
        test_bad_addr();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
